// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C byte master: register map, command/status
// bit positions, command record and FSM encoding.
package i2c_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_CMD  = 3'd1;
  localparam logic [2:0] ADDR_CTRL = 3'd2;
  localparam logic [2:0] ADDR_IE   = 3'd3;
  localparam logic [2:0] ADDR_DIVL = 3'd4;
  localparam logic [2:0] ADDR_DIVH = 3'd5;

  localparam int CMD_STA  = 0;
  localparam int CMD_STO  = 1;
  localparam int CMD_WR   = 2;
  localparam int CMD_RD   = 3;
  localparam int CMD_NACK = 4;

  localparam int CTL_IE       = 0;
  localparam int CTL_CLR_ERR  = 1;
  localparam int CTL_CLR_DONE = 2;

  localparam int ST_BUSY  = 0;
  localparam int ST_RXACK = 1;
  localparam int ST_DONE  = 2;
  localparam int ST_ERR   = 3;

  localparam int MIN_DIV = 3;

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, HOLD} state_t;

  typedef struct packed {
    logic nack;
    logic rd;
    logic wr;
    logic sto;
  } cmd_t;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit prescaler: one-cycle tick every (div+1) clocks, restartable so
// the first quarter of a command is always full length.
module i2c_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (restart || (cnt == '0)) begin
      cnt <= div;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/i2c_byte_master.sv
// Avalon-MM I2C byte master: START / 8-bit write or read with ACK / STOP,
// sequenced in quarter-bit steps from a programmable prescaler.
module i2c_byte_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 124,
  parameter int DIV_W   = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       irq,
  inout  wire        coe_sda,
  output logic       coe_scl
);

  state_t           state, state_n;
  logic [1:0]       q, q_n;
  logic [2:0]       bit_cnt, bit_n;
  logic [7:0]       shreg, shreg_n, txdata, rxdata, rx_n, status, rd_mux;
  cmd_t             cmd_q, cmd_n;
  logic             rxack, rxack_n, done, err, ie;
  logic [DIV_W-1:0] div_q;
  logic             sda_lvl, sda_n, scl_q, scl_n;
  logic             sda_p0, sda_p1;
  logic             wr_en, rd_en, cmd_wr, ctrl_wr, cmd_bad, accept, busy, tick, done_set;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
    return (v < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : v;
  endfunction

  assign wr_en   = chipselect && !write_n;
  assign rd_en   = chipselect && write_n;
  assign cmd_wr  = wr_en && (address == ADDR_CMD);
  assign ctrl_wr = wr_en && (address == ADDR_CTRL);
  assign busy    = (state != IDLE) && (state != HOLD);
  assign cmd_bad = busy || (writedata[CMD_WR] && writedata[CMD_RD]);
  assign accept  = cmd_wr && !cmd_bad && (writedata[4:0] != 5'd0);

  i2c_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (accept),
    .div     (div_q),
    .tick    (tick)
  );

  always_comb begin
    state_n  = state;
    q_n      = q;
    bit_n    = bit_cnt;
    shreg_n  = shreg;
    rx_n     = rxdata;
    rxack_n  = rxack;
    cmd_n    = cmd_q;
    done_set = 1'b0;
    sda_n    = sda_lvl;
    scl_n    = scl_q;
    if (accept) begin
      cmd_n.nack = writedata[CMD_NACK];
      cmd_n.rd   = writedata[CMD_RD];
      cmd_n.wr   = writedata[CMD_WR];
      cmd_n.sto  = writedata[CMD_STO];
      q_n        = 2'd0;
      bit_n      = 3'd0;
      shreg_n    = txdata;
      if (writedata[CMD_STA])                          state_n = START;
      else if (writedata[CMD_WR] || writedata[CMD_RD]) state_n = BIT;
      else                                             state_n = STOP;
    end else if (tick && busy) begin
      q_n = q + 2'd1;
      unique case (state)
        START: if (q == 2'd3) begin
          if (cmd_q.wr || cmd_q.rd) begin
            state_n = BIT;
            bit_n   = 3'd0;
            shreg_n = txdata;
          end else if (cmd_q.sto) begin
            state_n = STOP;
          end else begin
            state_n  = HOLD;
            done_set = 1'b1;
          end
        end
        BIT: begin
          if ((q == 2'd1) && cmd_q.rd) shreg_n = {shreg[6:0], sda_p1};
          if (q == 2'd3) begin
            if (cmd_q.wr) shreg_n = {shreg[6:0], 1'b0};
            bit_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_n = ACK;
              if (cmd_q.rd) rx_n = shreg;
            end
          end
        end
        ACK: begin
          if ((q == 2'd1) && cmd_q.wr) rxack_n = sda_p1;
          if (q == 2'd3) begin
            if (cmd_q.sto) begin
              state_n = STOP;
            end else begin
              state_n  = HOLD;
              done_set = 1'b1;
            end
          end
        end
        STOP: if (q == 2'd3) begin
          state_n  = IDLE;
          done_set = 1'b1;
        end
        default: ;
      endcase
    end
    // Pin levels follow the next state so SDA/SCL come straight from flops.
    unique case (state_n)
      IDLE:  begin sda_n = 1'b1; scl_n = 1'b1; end
      START: begin sda_n = (q_n < 2'd2); scl_n = (q_n != 2'd3); end
      BIT:   begin sda_n = cmd_n.wr ? shreg_n[7] : 1'b1; scl_n = q_n[0] ^ q_n[1]; end
      ACK:   begin sda_n = cmd_n.wr ? 1'b1 : cmd_n.nack; scl_n = q_n[0] ^ q_n[1]; end
      STOP:  begin sda_n = q_n[1]; scl_n = (q_n != 2'd0); end
      HOLD:  scl_n = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      q       <= 2'd0;
      bit_cnt <= 3'd0;
      shreg   <= 8'd0;
      rxdata  <= 8'd0;
      rxack   <= 1'b0;
      cmd_q   <= '0;
      sda_lvl <= 1'b1;
      scl_q   <= 1'b1;
    end else begin
      state   <= state_n;
      q       <= q_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      rxdata  <= rx_n;
      rxack   <= rxack_n;
      cmd_q   <= cmd_n;
      sda_lvl <= sda_n;
      scl_q   <= scl_n;
    end
  end

  // SDA synchronizer stages p0 -> p1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      sda_p0 <= coe_sda;
      sda_p1 <= sda_p0;
    end
  end

  always_comb begin
    status           = 8'd0;
    status[ST_BUSY]  = busy;
    status[ST_RXACK] = rxack;
    status[ST_DONE]  = done;
    status[ST_ERR]   = err;
    case (address)
      ADDR_DATA: rd_mux = rxdata;
      ADDR_CTRL: rd_mux = status;
      ADDR_IE:   rd_mux = {7'd0, ie};
      ADDR_DIVL: rd_mux = div_q[7:0];
      ADDR_DIVH: rd_mux = div_q[15:8];
      default:   rd_mux = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txdata   <= 8'd0;
      ie       <= 1'b0;
      err      <= 1'b0;
      done     <= 1'b0;
      div_q    <= DIV_W'(CLK_DIV);
      readdata <= 8'd0;
    end else begin
      if (wr_en) begin
        case (address)
          ADDR_DATA: txdata <= writedata;
          ADDR_CTRL: ie     <= writedata[CTL_IE];
          ADDR_DIVL: div_q  <= clamp_div({div_q[15:8], writedata});
          ADDR_DIVH: div_q  <= clamp_div({writedata, div_q[7:0]});
          default: ;
        endcase
      end
      if (cmd_wr && cmd_bad)                     err <= 1'b1;
      else if (ctrl_wr && writedata[CTL_CLR_ERR]) err <= 1'b0;
      if (done_set)                                                 done <= 1'b1;
      else if (accept || (ctrl_wr && writedata[CTL_CLR_DONE]))      done <= 1'b0;
      if (rd_en) readdata <= rd_mux;
    end
  end

  assign coe_sda = sda_lvl ? 1'bz : 1'b0;
  assign coe_scl = scl_q;
  assign irq     = done & ie;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master: bus accesses, quarter-by-quarter SDA/SCL
// waveform against hand-built sequences, flag behaviour and async reset.
module tb_i2c_byte_master;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] address = 3'd0;
  logic       chipselect = 1'b0;
  logic       write_n = 1'b1;
  logic [7:0] writedata = 8'd0;
  logic [7:0] readdata;
  logic       irq;
  logic       scl;
  wire        sda;
  logic       slave_low = 1'b0;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  int n_cmp = 0;
  int n_bad = 0;

  logic q_sda [0:63];
  logic q_scl [0:63];
  logic q_slv [0:63];
  logic obs_sda [0:63];
  logic obs_scl [0:63];
  int   n_q;
  logic [7:0] inj_rd;
  logic [7:0] rd;

  always #5 clk = ~clk;

  i2c_byte_master dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .coe_sda    (sda),
    .coe_scl    (scl)
  );

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk); #1;
    chipselect = 1'b0;
    d = readdata;
  endtask

  task automatic add_q(input logic m, input logic c, input logic s);
    q_sda[n_q] = m & ~s;
    q_scl[n_q] = c;
    q_slv[n_q] = s;
    n_q++;
  endtask

  task automatic add_bit(input logic d, input logic s);
    add_q(d, 1'b0, s); add_q(d, 1'b1, s); add_q(d, 1'b1, s); add_q(d, 1'b0, s);
  endtask

  // Expected bus levels per quarter; slave drives ACK (WR) or data bits (RD).
  task automatic build_seq(input logic sta, input logic wr, input logic rdc, input logic sto,
                           input logic nack, input logic [7:0] tx, input logic [7:0] slv,
                           input logic ack);
    n_q = 0;
    if (sta) begin
      add_q(1, 1, 0); add_q(1, 1, 0); add_q(0, 1, 0); add_q(0, 0, 0);
    end
    if (wr) begin
      for (int i = 7; i >= 0; i--) add_bit(tx[i], 1'b0);
      add_bit(1'b1, ack);
    end
    if (rdc) begin
      for (int i = 7; i >= 0; i--) add_bit(1'b1, !slv[i]);
      add_bit(nack, 1'b0);
    end
    if (sto) begin
      add_q(0, 0, 0); add_q(0, 1, 0); add_q(1, 1, 0); add_q(1, 1, 0);
    end
  endtask

  // Issues the command and samples SDA/SCL mid-quarter (DIV=3 -> 4 clk per quarter).
  task automatic run_seq(input logic [7:0] cmd, input int inj_q);
    bus_write(3'd1, cmd);
    for (int k = 0; k < n_q; k++) begin
      slave_low = q_slv[k];
      if (k == inj_q) bus_write(3'd1, 8'h02);
      else if (k == inj_q + 1) bus_read(3'd2, inj_rd);
      else @(posedge clk);
      @(posedge clk); #1;
      obs_sda[k] = sda;
      obs_scl[k] = scl;
      repeat (2) @(posedge clk);
      #1;
    end
    slave_low = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (scl !== 1'b1) begin n_bad++; $display("FAIL rst_scl: got %b want 1", scl); end
    n_cmp++; if (sda !== 1'b1) begin n_bad++; $display("FAIL rst_sda: got %b want 1", sda); end
    n_cmp++; if (readdata !== 8'h00) begin n_bad++; $display("FAIL rst_readdata: got %h want 00", readdata); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b want 0", irq); end
    @(negedge clk); reset_n = 1'b1;
    bus_read(3'd2, rd);
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL rst_status: got %h want 00", rd); end
    bus_read(3'd4, rd);
    n_cmp++; if (rd !== 8'd124) begin n_bad++; $display("FAIL rst_divl: got %h want 7c", rd); end
    bus_read(3'd5, rd);
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL rst_divh: got %h want 00", rd); end
  endtask

  task automatic test_write_ack;
    bus_write(3'd5, 8'h00);
    bus_write(3'd4, 8'h01);
    bus_read(3'd4, rd);
    n_cmp++; if (rd !== 8'h03) begin n_bad++; $display("FAIL div_clamp: got %h want 03", rd); end
    bus_write(3'd0, 8'hA5);
    bus_write(3'd2, 8'h01);
    build_seq(1, 1, 0, 1, 0, 8'hA5, 8'h00, 1);
    run_seq(8'h07, 999);
    for (int k = 0; k < n_q; k++) begin
      n_cmp++;
      if (obs_sda[k] !== q_sda[k] || obs_scl[k] !== q_scl[k]) begin
        n_bad++;
        $display("FAIL wr_wave q%0d: sda,scl got %b%b want %b%b", k, obs_sda[k], obs_scl[k], q_sda[k], q_scl[k]);
      end
    end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL wr_irq: got %b want 1", irq); end
    bus_read(3'd2, rd);
    n_cmp++; if (rd !== 8'h04) begin n_bad++; $display("FAIL wr_status: got %h want 04", rd); end
    bus_write(3'd2, 8'h05);
    bus_read(3'd2, rd);
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL clr_done: got %h want 00", rd); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL clr_irq: got %b want 0", irq); end
  endtask

  task automatic test_read_nack;
    build_seq(0, 0, 1, 1, 1, 8'h00, 8'h3C, 0);
    run_seq(8'h1A, 999);
    for (int k = 0; k < n_q; k++) begin
      n_cmp++;
      if (obs_sda[k] !== q_sda[k] || obs_scl[k] !== q_scl[k]) begin
        n_bad++;
        $display("FAIL rd_wave q%0d: sda,scl got %b%b want %b%b", k, obs_sda[k], obs_scl[k], q_sda[k], q_scl[k]);
      end
    end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL rd_irq: got %b want 1", irq); end
    bus_read(3'd0, rd);
    n_cmp++; if (rd !== 8'h3C) begin n_bad++; $display("FAIL rd_rxdata: got %h want 3c", rd); end
    bus_read(3'd2, rd);
    n_cmp++; if (rd !== 8'h04) begin n_bad++; $display("FAIL rd_status: got %h want 04", rd); end
  endtask

  task automatic test_no_slave;
    build_seq(0, 1, 0, 0, 0, 8'hA5, 8'h00, 0);
    run_seq(8'h04, 999);
    for (int k = 0; k < n_q; k++) begin
      n_cmp++;
      if (obs_sda[k] !== q_sda[k] || obs_scl[k] !== q_scl[k]) begin
        n_bad++;
        $display("FAIL ns_wave q%0d: sda,scl got %b%b want %b%b", k, obs_sda[k], obs_scl[k], q_sda[k], q_scl[k]);
      end
    end
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (scl !== 1'b0) begin n_bad++; $display("FAIL hold_scl: got %b want 0", scl); end
    n_cmp++; if (sda !== 1'b1) begin n_bad++; $display("FAIL hold_sda: got %b want 1", sda); end
    bus_read(3'd2, rd);
    n_cmp++; if (rd !== 8'h06) begin n_bad++; $display("FAIL ns_status: got %h want 06", rd); end
  endtask

  task automatic test_busy_error;
    bus_write(3'd0, 8'h5A);
    build_seq(1, 1, 0, 1, 0, 8'h5A, 8'h00, 1);
    run_seq(8'h07, 10);
    for (int k = 0; k < n_q; k++) begin
      n_cmp++;
      if (obs_sda[k] !== q_sda[k] || obs_scl[k] !== q_scl[k]) begin
        n_bad++;
        $display("FAIL be_wave q%0d: sda,scl got %b%b want %b%b", k, obs_sda[k], obs_scl[k], q_sda[k], q_scl[k]);
      end
    end
    n_cmp++;
    if ({inj_rd[3], inj_rd[2], inj_rd[0]} !== 3'b101) begin
      n_bad++; $display("FAIL busy_err_mid: status got %h want err=1 done=0 busy=1", inj_rd);
    end
    bus_read(3'd2, rd);
    n_cmp++; if (rd !== 8'h0C) begin n_bad++; $display("FAIL be_status: got %h want 0c", rd); end
    bus_write(3'd2, 8'h02);
    bus_read(3'd2, rd);
    n_cmp++; if (rd !== 8'h04) begin n_bad++; $display("FAIL clr_err: got %h want 04", rd); end
    bus_write(3'd1, 8'h0C);
    repeat (8) @(posedge clk);
    #1;
    n_cmp++; if (scl !== 1'b1) begin n_bad++; $display("FAIL wrrd_idle_scl: got %b want 1", scl); end
    bus_read(3'd2, rd);
    n_cmp++; if (rd !== 8'h0C) begin n_bad++; $display("FAIL wrrd_status: got %h want 0c", rd); end
    bus_write(3'd2, 8'h02);
    bus_read(3'd2, rd);
    n_cmp++; if (rd !== 8'h04) begin n_bad++; $display("FAIL clr_err2: got %h want 04", rd); end
  endtask

  task automatic test_reset_mid;
    bus_write(3'd0, 8'h00);
    bus_write(3'd1, 8'h07);
    repeat (16) @(posedge clk);
    #1;
    n_cmp++;
    if ({sda, scl} !== 2'b00) begin n_bad++; $display("FAIL mid_bit: sda,scl got %b%b want 00", sda, scl); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (scl !== 1'b1) begin n_bad++; $display("FAIL async_scl: got %b want 1", scl); end
    n_cmp++; if (sda !== 1'b1) begin n_bad++; $display("FAIL async_sda: got %b want 1", sda); end
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    bus_read(3'd2, rd);
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL rst2_status: got %h want 00", rd); end
    bus_read(3'd4, rd);
    n_cmp++; if (rd !== 8'd124) begin n_bad++; $display("FAIL rst2_divl: got %h want 7c", rd); end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if ({sda, scl} !== 2'b11) begin n_bad++; $display("FAIL rst2_idle: sda,scl got %b%b want 11", sda, scl); end
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_read_nack();
    test_no_slave();
    test_busy_error();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
